// File: rtl/pingpong_pkg.sv
// Shared constants and types for the ping-pong bank controller.
//   BANK_DEPTH  : words per bank for the default bank address width
//   FIFO_DEPTH  : entries in the output skid FIFO
//   FIFO_CW     : width of the FIFO occupancy count
//   bank_e      : bank selector (MSB of the RAM address)
//   bank_depth(): words per bank for an arbitrary bank address width
package pingpong_pkg;

    localparam int unsigned DEFAULT_BANK_AW = 5;
    localparam int unsigned BANK_DEPTH      = 2 ** DEFAULT_BANK_AW;
    localparam int unsigned FIFO_DEPTH      = 2;
    localparam int unsigned FIFO_CW         = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_e;

    function automatic int unsigned bank_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/pp_out_fifo.sv
// Two-entry output FIFO holding read data plus its end-of-bank flag.
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_data/last  : write one entry (caller guarantees not full)
//   pop                   : drop the head entry (caller guarantees not empty)
//   head_data, head_last  : current head entry
//   count                 : current occupancy
module pp_out_fifo
    import pingpong_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [FIFO_CW-1:0]    count
);

    localparam int unsigned IW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic                  last_q [FIFO_DEPTH];
    logic [IW-1:0]         rd_idx;
    logic [IW-1:0]         wr_idx;

    // Depth is a power of two, so index increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_idx] <= push_data;
                last_q[wr_idx] <= push_last;
                wr_idx         <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head_data = data_q[rd_idx];
        head_last = last_q[rd_idx];
    end

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong bank controller in front of a dual-port RAM.
// Writer fills one bank of 2**BANK_AW words through port A while the reader
// drains the other, complete bank through port B into a 2-entry output FIFO.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data       : input word stream
//   m_valid/m_ready/m_data/m_last: output word stream, m_last ends a bank
//   ram_wren/ram_waddr/ram_wdata : RAM port A (write only)
//   ram_rden/ram_raddr/ram_rdata : RAM port B (read only, 1-cycle latency)
//   bank_full                    : per-bank full flags
module pingpong_ctrl
    import pingpong_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BANK_AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  ram_wren,
    output logic [BANK_AW:0]      ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_rden,
    output logic [BANK_AW:0]      ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [1:0]            bank_full
);

    localparam logic [BANK_AW-1:0] PTR_LAST   = BANK_AW'(bank_depth(BANK_AW) - 1);
    localparam logic [FIFO_CW:0]   CREDIT_MAX = (FIFO_CW + 1)'(FIFO_DEPTH);

    logic [BANK_AW-1:0]    wr_ptr;
    logic [BANK_AW-1:0]    rd_ptr;
    bank_e                 wr_bank;
    bank_e                 rd_bank;
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  inflight;
    logic                  inflight_last;

    logic                  wr_fire;
    logic                  wr_wrap;
    logic                  rd_fire;
    logic                  rd_wrap;
    logic [FIFO_CW:0]      credit;

    logic [FIFO_CW-1:0]    fifo_count;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;

    always_comb begin
        // Nothing is accepted or issued while reset is held.
        s_ready   = rst_n && !full_q[wr_bank];
        wr_fire   = s_valid && s_ready;
        wr_wrap   = wr_fire && (wr_ptr == PTR_LAST);
        ram_wren  = wr_fire;
        ram_waddr = {wr_bank, wr_ptr};
        ram_wdata = s_data;

        credit    = {1'b0, fifo_count} + {{FIFO_CW{1'b0}}, inflight};
        rd_fire   = rst_n && full_q[rd_bank] && (credit < CREDIT_MAX);
        rd_wrap   = rd_fire && (rd_ptr == PTR_LAST);
        ram_rden  = rd_fire;
        ram_raddr = {rd_bank, rd_ptr};

        // Set and clear always address different banks, so both apply.
        full_d = full_q;
        if (wr_wrap) full_d[wr_bank] = 1'b1;
        if (rd_wrap) full_d[rd_bank] = 1'b0;
        bank_full = full_q;
    end

    // Returning read data bypasses the empty FIFO straight to the output;
    // it is only stored when the FIFO already holds older words or the
    // consumer stalls. This gives one word per cycle with the 2-slot credit.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        m_valid    = !fifo_empty || inflight;
        if (!fifo_empty) begin
            m_data = head_data;
            m_last = head_last;
        end else if (inflight) begin
            m_data = ram_rdata;
            m_last = inflight_last;
        end else begin
            m_data = '0;
            m_last = 1'b0;
        end
        fifo_pop  = !fifo_empty && m_ready;
        fifo_push = inflight && !(fifo_empty && m_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wr_bank       <= BANK_0;
            rd_bank       <= BANK_0;
            full_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (wr_wrap) wr_bank <= (wr_bank == BANK_0) ? BANK_1 : BANK_0;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            if (rd_wrap) rd_bank <= (rd_bank == BANK_0) ? BANK_1 : BANK_0;
            full_q        <= full_d;
            inflight      <= rd_fire;
            inflight_last <= rd_wrap;
        end
    end

    pp_out_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(ram_rdata),
        .push_last(inflight_last),
        .pop      (fifo_pop),
        .head_data(head_data),
        .head_last(head_last),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Scoreboard bench for pingpong_ctrl with a behavioural RAM and a word-level
// reference model: accepted words collect per bank and only complete banks
// become expected output, in arrival order, last flag on each 32nd word.
module tb_pingpong_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ram_wren;
    logic [AW:0]   ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_rden;
    logic [AW:0]   ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    bank_full;

    always #5 clk = ~clk;

    pingpong_ctrl #(
        .DATA_WIDTH(DW),
        .BANK_AW   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .ram_wren (ram_wren),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_rden (ram_rden),
        .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata),
        .bank_full(bank_full)
    );

    logic [DW-1:0] mem [2*DEPTH];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_waddr] <= ram_wdata;
        if (ram_rden) ram_rdata <= mem[ram_raddr];
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_out = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic [DW-1:0] pend [$];
    exp_t          expq [$];

    int track   = 0;
    int acc_cyc = -1;
    int r_cyc   = -1;
    int v_cyc   = -1;
    int mr_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            2:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Input side of the reference model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend.delete();
            expq.delete();
        end else if (s_valid && s_ready) begin
            pend.push_back(s_data);
            if (pend.size() == DEPTH) begin
                if (track != 0 && acc_cyc < 0) acc_cyc = cyc;
                for (int i = 0; i < DEPTH; i++) expq.push_back('{d: pend[i], l: (i == DEPTH - 1)});
                pend.delete();
            end
        end
    end

    // Output monitor: scoreboard, stall stability and port safety.
    initial begin
        logic          held;
        logic [DW-1:0] held_d;
        logic          held_l;
        exp_t          e;
        held = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (track != 0 && ram_rden && r_cyc < 0) r_cyc = cyc;
                if (track != 0 && m_valid && v_cyc < 0) v_cyc = cyc;
                if (held) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'(m_data), 32'(held_d));
                    check("hold_last", 32'(m_last), 32'(held_l));
                end
                held   = m_valid && !m_ready;
                held_d = m_data;
                held_l = m_last;
                if (m_valid && m_ready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_word", 32'(expq.size()), 32'd1);
                    end else begin
                        e = expq.pop_front();
                        check("m_data", 32'(m_data), 32'(e.d));
                        check("m_last", 32'(m_last), 32'(e.l));
                        n_out++;
                    end
                end
                if (ram_wren && ram_rden) check("addr_hazard", 32'(ram_waddr == ram_raddr), 32'd0);
            end else begin
                held = 1'b0;
                check("reset_no_wren", 32'(ram_wren), 32'd0);
                check("reset_no_rden", 32'(ram_rden), 32'd0);
            end
        end
    end

    task automatic drive(input int sent, input bit rnd, input int base);
        s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = (base >= 0) ? DW'(base + sent) : DW'($urandom);
    endtask

    // base < 0 selects random data; otherwise data = base + word index.
    task automatic send(input int n, input bit rnd, input int base);
        int sent  = 0;
        int guard = 0;
        @(posedge clk);
        #1;
        drive(sent, rnd, base);
        while (sent < n && guard < 20000) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
            if (sent < n) drive(sent, rnd, base);
            else s_valid = 1'b0;
            guard++;
        end
        s_valid = 1'b0;
        if (sent < n) check("send_timeout", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        while ((expq.size() != 0 || m_valid) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int t31;
        int trise;
        // Reset with s_valid asserted: no write may reach the RAM.
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_ram_rden", 32'(ram_rden), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_bank_full", 32'(bank_full), 32'd0);

        // 64 sequential words, consumer always ready; latency of first bank.
        mr_mode = 0;
        track = 1;
        send(64, 1'b0, 0);
        drain();
        track = 0;
        check("rden_latency", 32'(r_cyc - acc_cyc), 32'd1);
        check("mvalid_latency", 32'(v_cyc - acc_cyc), 32'd2);
        check("out_after_64", 32'(n_out), 32'd64);

        // Both banks fill while the consumer stalls.
        mr_mode = 1;
        send(64, 1'b0, 0);
        repeat (5) @(negedge clk);
        check("both_full", 32'(bank_full), 32'd3);
        check("stalled_s_ready", 32'(s_ready), 32'd0);
        mr_mode = 0;
        t31 = -1;
        trise = -1;
        for (int i = 0; i < 200 && trise < 0; i++) begin
            @(negedge clk);
            if (t31 >= 0 && s_ready) trise = cyc;
            if (t31 < 0 && ram_rden && ram_raddr == 6'd31) t31 = cyc;
        end
        check("s_ready_release", 32'(trise - t31), 32'd1);
        drain();
        check("out_after_128", 32'(n_out), 32'd128);

        // Consumer toggling every cycle over three banks.
        mr_mode = 2;
        send(96, 1'b0, 0);
        drain();
        check("out_after_224", 32'(n_out), 32'd224);

        // Reset in the middle of a partial bank.
        mr_mode = 0;
        send(20, 1'b0, 100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_bank_full", 32'(bank_full), 32'd0);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        check("midrst_bank_full2", 32'(bank_full), 32'd0);
        send(32, 1'b0, 0);
        drain();
        check("out_after_256", 32'(n_out), 32'd256);

        // Random traffic on both sides.
        mr_mode = 3;
        send(1024, 1'b1, -1);
        mr_mode = 0;
        drain();
        check("out_total", 32'(n_out), 32'd1280);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width.
REQ-002 SHALL have parameter BANK_AW, default 5, meaning per-bank address width (BANK_DEPTH = 2**BANK_AW words per bank).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  single clock for all logic and both RAM ports.
REQ-004 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have s_valid  in  1  input word valid.
REQ-006 SHALL have s_ready  out  1  input word accepted when s_valid&&s_ready.
REQ-007 SHALL have s_data  in  DATA_WIDTH  input word.
REQ-008 SHALL have m_valid  out  1  output word valid.
REQ-009 SHALL have m_ready  in  1  downstream accepts when m_valid&&m_ready.
REQ-010 SHALL have m_data  out  DATA_WIDTH  output word.
REQ-011 SHALL have m_last  out  1  marks last word of a bank.
REQ-012 SHALL have ram_wren  out  1  dp_ram port A write enable.
REQ-013 SHALL have ram_waddr  out  BANK_AW+1  port A address, MSB = bank.
REQ-014 SHALL have ram_wdata  out  DATA_WIDTH  port A write data.
REQ-015 SHALL have ram_rden  out  1  dp_ram port B read enable.
REQ-016 SHALL have ram_raddr  out  BANK_AW+1  port B address, MSB = bank.
REQ-017 SHALL have ram_rdata  in  DATA_WIDTH  port B read data, valid one cycle after ram_rden.
REQ-018 SHALL have bank_full  out  2  per-bank full flags.

Function
REQ-019 SHALL write port A only and read port B only; dp_ram wren_b/rden_a tie-off done at instantiation.
REQ-020 SHALL drive ram_wren = s_valid&&s_ready, ram_waddr = {wr_bank,wr_ptr}, ram_wdata = s_data, combinationally.
REQ-021 SHALL drive s_ready = !bank_full[wr_bank].
REQ-022 SHALL increment wr_ptr per write; on write at wr_ptr = BANK_DEPTH-1: wr_ptr wraps to 0, bank_full[wr_bank] set, wr_bank toggles.
REQ-023 SHALL issue a read (ram_rden=1, ram_raddr={rd_bank,rd_ptr}) when bank_full[rd_bank] && (out_count + inflight) < 2.
REQ-024 SHALL increment rd_ptr per issued read; on read at rd_ptr = BANK_DEPTH-1: rd_ptr wraps to 0, bank_full[rd_bank] cleared, rd_bank toggles.
REQ-025 SHALL capture ram_rdata one cycle after ram_rden into a 2-entry output FIFO together with its last flag (rd_ptr was BANK_DEPTH-1); never drop or duplicate a word.
REQ-026 SHALL present FIFO head on m_data/m_last with m_valid = FIFO non-empty; m_data/m_last SHALL hold stable while m_valid&&!m_ready.
REQ-027 SHALL sustain one word/cycle through output when m_ready stays 1.
REQ-028 Latency: last write of a bank at edge N -> bank_full set after N, ram_rden at cycle N+1, m_valid first high cycle N+2.
REQ-029 Simultaneous set (writer) and clear (reader) target different banks by construction; both SHALL take effect same edge.
REQ-030 Both banks full: s_ready=0 until the reader releases a bank; writer SHALL resume on cycle after release.
REQ-031 Output order SHALL equal input order across bank switches.

Reset
REQ-032 On rst_n=0: wr_ptr=rd_ptr=0, wr_bank=rd_bank=0, bank_full=2'b00, FIFO empty, inflight=0; outputs m_valid=0, m_data=0, m_last=0, ram_rden=0, s_ready=1 after reset; partial bank contents discarded.
REQ-033 Reset asserted mid-bank SHALL abort both streams immediately; no RAM write/read issued while rst_n=0.

Structure
REQ-034 BANK_DEPTH localparam and FIFO depth constant (2) SHALL live in a shared package pingpong_pkg.
REQ-035 Output FIFO SHALL be a sub-module pp_out_fifo (2-entry, data+last, count output).

Verification (BANK_AW=5, BANK_DEPTH=32, data=index)
REQ-036 Stream 64 words 0..63, m_ready=1 -> outputs 0..63 in order, m_last on 31 and 63, first m_valid 2 cycles after word 31 accepted.
REQ-037 Continuous write, m_ready=0 -> s_ready drops after word 63, bank_full=2'b11; release m_ready -> 0..63 out, s_ready rises after read of address 31 issued.
REQ-038 m_ready toggling 1/0 every cycle over 96 words -> no loss/duplication, m_data stable while stalled.
REQ-039 Write 20 words, assert rst_n=0 -> bank_full=0, m_valid=0, s_ready=1; next 32 words out starting at 0 with m_last on word 31.
REQ-040 Random s_valid/m_ready (50%) for 1000 words -> scoreboard match, ram_waddr and ram_raddr never same address with write pending unread.
